// File: rtl/rgb2gray_frame_ctrl.sv
// Frame sequencer for the RGB-to-grayscale datapath: accepts one frame of pixels,
// enables the datapath and carries frame position tags alongside it to the output.
module rgb2gray_frame_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIPE_LAT   = 3,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic abort_i,
    input  logic valid_i,
    output logic ready_o,
    output logic dp_en_o,
    output logic valid_o,
    output logic sof_o,
    output logic eol_o,
    output logic eof_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o
);

    // state | meaning
    // IDLE  | waiting for start_i, datapath stopped
    // RUN   | accepting pixels of the current frame
    // DRAIN | all pixels accepted, flushing the datapath until eof leaves it
    // DONE  | frame fully emitted, done_o pulse
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // tag bit positions: {valid, sof, eol, eof}
    localparam int TAG_V   = 3;
    localparam int TAG_SOF = 2;
    localparam int TAG_EOL = 1;
    localparam int TAG_EOF = 0;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [3:0]       tag_pipe [PIPE_LAT];
    logic [3:0]       tag_in;
    logic [3:0]       tag_out;
    logic             accept;
    logic             last;
    logic             frame_start;
    logic             err;

    assign ready_o     = (state == S_RUN);
    assign dp_en_o     = (state == S_RUN) || (state == S_DRAIN);
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE) && !abort_i;
    assign err_o       = err;

    // Abort takes priority over everything, including a pixel offered in the same cycle.
    assign accept      = valid_i && ready_o && !abort_i;
    assign last        = (col == COL_LAST) && (row == ROW_LAST);
    assign frame_start = (state == S_IDLE) && start_i && !abort_i;

    assign tag_in[TAG_V]   = accept;
    assign tag_in[TAG_SOF] = accept && (col == '0) && (row == '0);
    assign tag_in[TAG_EOL] = accept && (col == COL_LAST);
    assign tag_in[TAG_EOF] = accept && last;

    assign tag_out = tag_pipe[PIPE_LAT-1];
    assign valid_o = tag_out[TAG_V];
    assign sof_o   = tag_out[TAG_SOF];
    assign eol_o   = tag_out[TAG_EOL];
    assign eof_o   = tag_out[TAG_EOF];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                end else if (accept && last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                end else if (tag_out[TAG_EOF]) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Row is cleared on the last pixel rather than incremented, so it never exceeds ROW_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (abort_i || frame_start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last) begin
                col <= '0;
                row <= '0;
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (frame_start) begin
            err <= 1'b0;
        end else if (valid_i && !ready_o && !abort_i) begin
            err <= 1'b1;
        end
    end

    // The DRAIN->DONE edge still shifts, so the eof tag leaves the last stage on time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else if (abort_i) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else if (dp_en_o) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            tag_pipe[0] <= tag_in;
        end
    end

endmodule

// File: tb/tb_rgb2gray_frame_ctrl.sv
// Directed bench for rgb2gray_frame_ctrl: a 4x2 frame on a PIPE_LAT=3 instance and a
// PIPE_LAT=1 instance sharing stimulus; per-cycle output traces compared to hand masks.
module tb_rgb2gray_frame_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic valid = 1'b0;

    logic a_ready, a_dp_en, a_valid, a_sof, a_eol, a_eof, a_busy, a_done, a_err;
    logic b_ready, b_dp_en, b_valid, b_sof, b_eol, b_eof, b_busy, b_done, b_err;

    logic [31:0] la_valid, la_sof, la_eol, la_eof, la_done, la_busy, la_err, la_ready, la_dp_en;
    logic [31:0] lb_valid, lb_sof, lb_eol, lb_eof, lb_done, lb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgb2gray_frame_ctrl #(
        .IMG_WIDTH(4), .IMG_HEIGHT(2), .PIPE_LAT(3), .COL_W(3), .ROW_W(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .valid_i(valid),
        .ready_o(a_ready), .dp_en_o(a_dp_en), .valid_o(a_valid), .sof_o(a_sof),
        .eol_o(a_eol), .eof_o(a_eof), .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
    );

    rgb2gray_frame_ctrl #(
        .IMG_WIDTH(4), .IMG_HEIGHT(2), .PIPE_LAT(1), .COL_W(3), .ROW_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .valid_i(valid),
        .ready_o(b_ready), .dp_en_o(b_dp_en), .valid_o(b_valid), .sof_o(b_sof),
        .eol_o(b_eol), .eof_o(b_eof), .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        abort = 1'b0;
        valid = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Bit c of each mask drives the inputs before edge c; bit c of each log is sampled 1 unit after it.
    task automatic run_seq(input logic [31:0] sm, input logic [31:0] vm, input logic [31:0] am,
                           input int n);
        la_valid = '0; la_sof = '0; la_eol = '0; la_eof = '0; la_done = '0;
        la_busy = '0; la_err = '0; la_ready = '0; la_dp_en = '0;
        lb_valid = '0; lb_sof = '0; lb_eol = '0; lb_eof = '0; lb_done = '0; lb_busy = '0;
        for (int c = 0; c < n; c++) begin
            start = sm[c];
            valid = vm[c];
            abort = am[c];
            @(posedge clk);
            #1;
            la_valid[c] = a_valid; la_sof[c]  = a_sof;  la_eol[c]   = a_eol;
            la_eof[c]   = a_eof;   la_done[c] = a_done; la_busy[c]  = a_busy;
            la_err[c]   = a_err;   la_ready[c] = a_ready; la_dp_en[c] = a_dp_en;
            lb_valid[c] = b_valid; lb_sof[c]  = b_sof;  lb_eol[c]   = b_eol;
            lb_eof[c]   = b_eof;   lb_done[c] = b_done; lb_busy[c]  = b_busy;
        end
        start = 1'b0;
        valid = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check_eq("reset_a", {23'd0, a_ready, a_dp_en, a_valid, a_sof, a_eol, a_eof,
                             a_busy, a_done, a_err}, 32'd0);
        check_eq("reset_b", {23'd0, b_ready, b_dp_en, b_valid, b_sof, b_eol, b_eof,
                             b_busy, b_done, b_err}, 32'd0);

        // back-to-back frame
        run_seq(32'h1, 32'h1FE, 32'h0, 16);
        check_eq("t1_valid", la_valid, 32'h07F8);
        check_eq("t1_sof",   la_sof,   32'h0008);
        check_eq("t1_eol",   la_eol,   32'h0440);
        check_eq("t1_eof",   la_eof,   32'h0400);
        check_eq("t1_done",  la_done,  32'h0800);
        check_eq("t1_busy",  la_busy,  32'h0FFF);
        check_eq("t1_ready", la_ready, 32'h00FF);
        check_eq("t1_dp_en", la_dp_en, 32'h07FF);
        check_eq("t1_err",   la_err,   32'h0000);
        check_eq("t1b_valid", lb_valid, 32'h01FE);
        check_eq("t1b_sof",   lb_sof,   32'h0002);
        check_eq("t1b_eol",   lb_eol,   32'h0110);
        check_eq("t1b_eof",   lb_eof,   32'h0100);
        check_eq("t1b_done",  lb_done,  32'h0200);
        check_eq("t1b_busy",  lb_busy,  32'h03FF);

        // gapped input: pixels on every other cycle
        do_reset();
        run_seq(32'h1, 32'hAAAA, 32'h0, 24);
        check_eq("t2_valid", la_valid, 32'h0002_AAA8);
        check_eq("t2_sof",   la_sof,   32'h0000_0008);
        check_eq("t2_eol",   la_eol,   32'h0002_0200);
        check_eq("t2_eof",   la_eof,   32'h0002_0000);
        check_eq("t2_done",  la_done,  32'h0004_0000);
        check_eq("t2_busy",  la_busy,  32'h0007_FFFF);

        // pixels offered in IDLE and DRAIN
        do_reset();
        run_seq(32'h2, 32'h0FFD, 32'h0, 16);
        check_eq("t3_err",   la_err,   32'hFC01);
        check_eq("t3_valid", la_valid, 32'h0FF0);
        check_eq("t3_sof",   la_sof,   32'h0010);
        check_eq("t3_eof",   la_eof,   32'h0800);
        check_eq("t3_done",  la_done,  32'h1000);

        // abort after pixel 5, then a fresh frame
        do_reset();
        run_seq(32'h0000_0201, 32'h0003_FCFE, 32'h0000_0080, 24);
        check_eq("t4_valid", la_valid, 32'h000F_F078);
        check_eq("t4_sof",   la_sof,   32'h0000_1008);
        check_eq("t4_eol",   la_eol,   32'h0008_8040);
        check_eq("t4_eof",   la_eof,   32'h0008_0000);
        check_eq("t4_done",  la_done,  32'h0010_0000);
        check_eq("t4_busy",  la_busy,  32'h001F_FE7F);
        check_eq("t4_err",   la_err,   32'h0000_0000);

        // asynchronous reset while draining
        do_reset();
        run_seq(32'h1, 32'h1FE, 32'h0, 10);
        check_eq("t5_pre_valid", {30'd0, a_valid, a_busy}, 32'h3);
        #3 rst = 1'b1;
        #1;
        check_eq("t5_async_a", {23'd0, a_ready, a_dp_en, a_valid, a_sof, a_eol, a_eof,
                                a_busy, a_done, a_err}, 32'd0);
        check_eq("t5_async_b", {23'd0, b_ready, b_dp_en, b_valid, b_sof, b_eol, b_eof,
                                b_busy, b_done, b_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_seq(32'h0, 32'h0, 32'h0, 6);
        check_eq("t5_done", la_done, 32'h0);
        check_eq("t5_busy", la_busy, 32'h0);
        check_eq("t5_valid", la_valid, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
